// File: rtl/stopwatch_time_sender_if.sv
// Purpose: request/field inputs and UART TX byte stream of the stopwatch time sender.
// Latency: none, wiring only.
// Backpressure: carries the i_tx_ready/o_tx_valid handshake unchanged.
interface stopwatch_time_sender_if;
  logic       i_send;
  logic [4:0] i_hour;
  logic [5:0] i_min;
  logic [5:0] i_sec;
  logic [6:0] i_msec;
  logic [7:0] o_tx_data;
  logic       o_tx_valid;
  logic       i_tx_ready;
  logic       o_busy;
  logic       o_done;

  // Requester / UART side: drives request, fields and ready.
  modport master (
    output i_send, i_hour, i_min, i_sec, i_msec, i_tx_ready,
    input  o_tx_data, o_tx_valid, o_busy, o_done
  );

  // Sender side.
  modport slave (
    input  i_send, i_hour, i_min, i_sec, i_msec, i_tx_ready,
    output o_tx_data, o_tx_valid, o_busy, o_done
  );
endinterface

// File: rtl/stopwatch_time_sender.sv
// Purpose: snapshots hour/min/sec/centisec and streams "HH:MM:SS.CC[\r\n]" as ASCII bytes.
// Latency: first byte valid the cycle after the i_send edge; LAST+1 bytes then one DONE cycle.
// Backpressure: o_tx_valid/o_tx_data and the byte index hold while i_tx_ready is low.
module stopwatch_time_sender #(
  parameter bit SEND_CRLF = 1'b1,
  parameter int SAT_VALUE = 99
) (
  input logic                   clk,
  input logic                   rst,
  stopwatch_time_sender_if.slave sw_if
);

  localparam logic [3:0] LAST = SEND_CRLF ? 4'd12 : 4'd10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [4:0] hour_q, hour_d;
  logic [5:0] min_q, min_d;
  logic [5:0] sec_q, sec_d;
  logic [6:0] msec_q, msec_d;
  logic [7:0] tx_byte;

  // Fields wider than two digits are replaced by the saturation value.
  function automatic logic [6:0] clamp(input logic [6:0] v);
    return (v > 7'd99) ? 7'(SAT_VALUE) : v;
  endfunction

  function automatic logic [7:0] tens_ascii(input logic [6:0] v);
    logic [6:0] c;
    c = clamp(v);
    return 8'h30 + {1'b0, c / 7'd10};
  endfunction

  function automatic logic [7:0] ones_ascii(input logic [6:0] v);
    logic [6:0] c;
    c = clamp(v);
    return 8'h30 + {1'b0, c % 7'd10};
  endfunction

  // State, index and snapshot registers; reset abandons any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
      hour_q  <= 5'd0;
      min_q   <= 6'd0;
      sec_q   <= 6'd0;
      msec_q  <= 7'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hour_q  <= hour_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      msec_q  <= msec_d;
    end
  end

  // Next state: capture on request in IDLE, advance index per accepted byte.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hour_d  = hour_q;
    min_d   = min_q;
    sec_d   = sec_q;
    msec_d  = msec_q;
    case (state_q)
      IDLE: begin
        if (sw_if.i_send) begin
          hour_d  = sw_if.i_hour;
          min_d   = sw_if.i_min;
          sec_d   = sw_if.i_sec;
          msec_d  = sw_if.i_msec;
          idx_d   = 4'd0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (sw_if.i_tx_ready) begin
          if (idx_q == LAST) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Byte selected purely from snapshot and index.
  always_comb begin
    tx_byte = 8'h00;
    case (idx_q)
      4'd0:  tx_byte = tens_ascii({2'b00, hour_q});
      4'd1:  tx_byte = ones_ascii({2'b00, hour_q});
      4'd2:  tx_byte = 8'h3A;
      4'd3:  tx_byte = tens_ascii({1'b0, min_q});
      4'd4:  tx_byte = ones_ascii({1'b0, min_q});
      4'd5:  tx_byte = 8'h3A;
      4'd6:  tx_byte = tens_ascii({1'b0, sec_q});
      4'd7:  tx_byte = ones_ascii({1'b0, sec_q});
      4'd8:  tx_byte = 8'h2E;
      4'd9:  tx_byte = tens_ascii(msec_q);
      4'd10: tx_byte = ones_ascii(msec_q);
      4'd11: tx_byte = 8'h0D;
      4'd12: tx_byte = 8'h0A;
      default: tx_byte = 8'h00;
    endcase
  end

  assign sw_if.o_tx_valid = (state_q == SEND);
  assign sw_if.o_tx_data  = (state_q == SEND) ? tx_byte : 8'h00;
  assign sw_if.o_busy     = (state_q != IDLE);
  assign sw_if.o_done     = (state_q == DONE);

endmodule

// File: tb/tb_stopwatch_time_sender.sv
// Purpose: random and directed frames on a CR/LF and a no-CR/LF instance against an ASCII model.
// Latency: checks first byte in the cycle after i_send and o_done right after the last byte.
// Backpressure: drives i_tx_ready always-on, 1-0-0 pattern and random; checks hold rule.
module tb_stopwatch_time_sender;

  logic clk;
  logic rst;

  stopwatch_time_sender_if sw1 ();
  stopwatch_time_sender_if sw0 ();

  // The no-CR/LF instance sees exactly the same stimulus.
  assign sw0.i_send     = sw1.i_send;
  assign sw0.i_hour     = sw1.i_hour;
  assign sw0.i_min      = sw1.i_min;
  assign sw0.i_sec      = sw1.i_sec;
  assign sw0.i_msec     = sw1.i_msec;
  assign sw0.i_tx_ready = sw1.i_tx_ready;

  stopwatch_time_sender #(.SEND_CRLF(1'b1), .SAT_VALUE(99)) dut1 (
    .clk(clk), .rst(rst), .sw_if(sw1)
  );
  stopwatch_time_sender #(.SEND_CRLF(1'b0), .SAT_VALUE(99)) dut0 (
    .clk(clk), .rst(rst), .sw_if(sw0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  logic [7:0] q1[$];
  logic [7:0] q0[$];
  int done1 = 0;
  int done0 = 0;
  logic       p_vld = 1'b0;
  logic       p_rdy = 1'b0;
  logic [7:0] p_dat = 8'h00;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: byte i of the ASCII frame for the given time.
  function automatic logic [7:0] exp_byte(input int h, input int m, input int s, input int c, input int i);
    int f[4];
    int v;
    f[0] = h; f[1] = m; f[2] = s; f[3] = c;
    if (i == 11) return 8'h0D;
    if (i == 12) return 8'h0A;
    if (i % 3 == 2) return (i == 8) ? 8'h2E : 8'h3A;
    v = f[i / 3];
    if (v > 99) v = 99;
    if (i % 3 == 0) return 8'(48 + v / 10);
    return 8'(48 + v % 10);
  endfunction

  // Observer: collects accepted bytes, done pulses, and checks the hold rule.
  always @(negedge clk) begin
    if (rst) begin
      p_vld = 1'b0;
    end else begin
      if (p_vld && !p_rdy) begin
        check_val("hold_vld", 32'(sw1.o_tx_valid), 32'd1);
        check_val("hold_dat", 32'(sw1.o_tx_data), 32'(p_dat));
      end
      if (sw1.o_tx_valid && sw1.i_tx_ready) q1.push_back(sw1.o_tx_data);
      if (sw0.o_tx_valid && sw0.i_tx_ready) q0.push_back(sw0.o_tx_data);
      if (sw1.o_done) begin
        done1++;
        check_val("done1_len", 32'(q1.size()), 32'd13);
        check_val("done1_vld", 32'(sw1.o_tx_valid), 32'd0);
        check_val("done1_busy", 32'(sw1.o_busy), 32'd1);
      end
      if (sw0.o_done) begin
        done0++;
        check_val("done0_len", 32'(q0.size()), 32'd11);
      end
      if (!sw1.o_busy) check_val("idle_vld", 32'(sw1.o_tx_valid), 32'd0);
      p_vld = sw1.o_tx_valid;
      p_rdy = sw1.i_tx_ready;
      p_dat = sw1.o_tx_data;
    end
  end

  function automatic logic ready_for(input int mode, input int cyc);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (cyc % 3 == 0);
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic set_fields(input int h, input int m, input int s, input int c);
    sw1.i_hour = 5'(h);
    sw1.i_min  = 6'(m);
    sw1.i_sec  = 6'(s);
    sw1.i_msec = 7'(c);
  endtask

  // One frame; if chg_at >= 0, fields change and i_send pulses once that many bytes in.
  task automatic run_frame(input int h, input int m, input int s, input int c,
                           input int mode, input int chg_at);
    int  cyc;
    bit  chg_done;
    chg_done = 1'b0;
    q1.delete(); q0.delete();
    done1 = 0; done0 = 0;
    set_fields(h, m, s, c);
    sw1.i_send = 1'b1;
    sw1.i_tx_ready = ready_for(mode, 0);
    @(posedge clk); #1;
    sw1.i_send = 1'b0;
    check_val("first_busy", 32'(sw1.o_busy), 32'd1);
    check_val("first_vld", 32'(sw1.o_tx_valid), 32'd1);
    check_val("first_dat", 32'(sw1.o_tx_data), 32'(exp_byte(h, m, s, c, 0)));
    cyc = 1;
    while ((done1 == 0 || done0 == 0) && cyc < 400) begin
      if (chg_at >= 0 && !chg_done && q1.size() == chg_at) begin
        set_fields(23, 59, 59, 99);
        sw1.i_send = 1'b1;
        chg_done = 1'b1;
      end else begin
        sw1.i_send = 1'b0;
      end
      sw1.i_tx_ready = ready_for(mode, cyc);
      @(posedge clk); #1;
      cyc++;
    end
    sw1.i_send = 1'b0;
    if (cyc >= 400) check_val("timeout", 32'd0, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check_val("n_done1", 32'(done1), 32'd1);
    check_val("n_done0", 32'(done0), 32'd1);
    check_val("len1", 32'(q1.size()), 32'd13);
    check_val("len0", 32'(q0.size()), 32'd11);
    check_val("end_busy", 32'(sw1.o_busy), 32'd0);
    for (int i = 0; i < 13; i++)
      if (i < q1.size()) check_val($sformatf("b1_%0d", i), 32'(q1[i]), 32'(exp_byte(h, m, s, c, i)));
    for (int i = 0; i < 11; i++)
      if (i < q0.size()) check_val($sformatf("b0_%0d", i), 32'(q0[i]), 32'(exp_byte(h, m, s, c, i)));
  endtask

  // Reset asserted mid-cycle once six bytes have gone out.
  task automatic reset_mid_frame();
    int cyc;
    q1.delete(); q0.delete();
    done1 = 0; done0 = 0;
    set_fields(12, 34, 56, 78);
    sw1.i_send = 1'b1;
    sw1.i_tx_ready = 1'b1;
    @(posedge clk); #1;
    sw1.i_send = 1'b0;
    cyc = 0;
    while (q1.size() < 6 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (cyc >= 50) check_val("rst_timeout", 32'd0, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_val("rst_vld1", 32'(sw1.o_tx_valid), 32'd0);
    check_val("rst_vld0", 32'(sw0.o_tx_valid), 32'd0);
    check_val("rst_dat", 32'(sw1.o_tx_data), 32'd0);
    check_val("rst_busy", 32'(sw1.o_busy), 32'd0);
    check_val("rst_done", 32'(sw1.o_done), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_val("rst_no_done1", 32'(done1), 32'd0);
    check_val("rst_no_done0", 32'(done0), 32'd0);
    check_val("rst_idle_vld", 32'(sw1.o_tx_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    sw1.i_send = 1'b0;
    sw1.i_tx_ready = 1'b0;
    set_fields(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check_val("r_vld", 32'(sw1.o_tx_valid), 32'd0);
    check_val("r_dat", 32'(sw1.o_tx_data), 32'd0);
    check_val("r_busy", 32'(sw1.o_busy), 32'd0);
    check_val("r_done", 32'(sw1.o_done), 32'd0);
    rst = 1'b0;
    sw1.i_tx_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_val("idle_vld_ready", 32'(sw1.o_tx_valid), 32'd0);
    check_val("idle_busy", 32'(sw1.o_busy), 32'd0);

    run_frame(1, 2, 3, 45, 0, -1);
    run_frame(1, 2, 3, 45, 1, -1);
    run_frame(1, 2, 3, 45, 0, 4);
    run_frame(23, 59, 59, 99, 0, -1);
    run_frame(31, 0, 9, 127, 1, -1);
    run_frame(0, 63, 63, 100, 2, -1);
    reset_mid_frame();
    run_frame(7, 8, 9, 10, 0, -1);
    for (int k = 0; k < 20; k++)
      run_frame(int'($urandom_range(0, 31)), int'($urandom_range(0, 63)),
                int'($urandom_range(0, 63)), int'($urandom_range(0, 127)),
                int'($urandom_range(0, 2)), -1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
